// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues sequential PC requests to instruction memory,
// buffers in-order responses with their PCs, and hands one instruction per cycle to decode.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);
    localparam int          AW  = $clog2(DEPTH);
    localparam int          CW  = $clog2(DEPTH + 1);
    localparam int          OW  = $clog2(MAX_OUT + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] count;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] discard;
    logic [OW-1:0] out_next;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   data_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   credit;
    logic [31:0]   target;
    logic          accept;
    logic          rsp;
    logic          push;
    logic          pop;
    logic          empty;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and imem_rvalid carries one response per cycle in order.
    assign empty    = (count == '0);
    assign credit   = 32'(count) + 32'(outstanding) - 32'(discard);
    assign target   = redirect_pc & ~32'h0000_0003;
    assign imem_req = rst && !redirect && (32'(outstanding) < 32'(MAX_OUT))
                      && (credit < 32'(DEPTH));
    assign imem_addr = fetch_pc;
    assign accept    = imem_req && imem_ready;
    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp       = imem_rvalid && (outstanding != '0);
    assign push      = rsp && (discard == '0) && !redirect;
    assign out_next  = outstanding + OW'(accept) - OW'(rsp);

    assign instr_valid = !redirect && !empty;
    assign pop         = instr_valid && instr_ready;
    assign instr       = empty ? NOP : data_mem[rd_ptr];
    // With an empty queue the head PC shows the next PC expected from memory.
    assign pc          = empty ? resp_pc : pc_mem[rd_ptr];
    assign pc_plus4    = pc + 32'd4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= out_next;
            if (redirect) begin
                // Everything still in flight after this edge is stale.
                fetch_pc <= target;
                resp_pc  <= target;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                discard  <= out_next;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp && (discard != '0)) begin
                    discard <= discard - OW'(1);
                end
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]   <= resp_pc;
        end
    end

    a_discard_le_out: assert property (@(posedge clk) disable iff (!rst)
        discard <= outstanding);
    a_out_le_max: assert property (@(posedge clk) disable iff (!rst)
        32'(outstanding) <= 32'(MAX_OUT));
    a_count_le_depth: assert property (@(posedge clk) disable iff (!rst)
        32'(count) <= 32'(DEPTH));
    a_credit_le_depth: assert property (@(posedge clk) disable iff (!rst)
        credit <= 32'(DEPTH));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a latency-programmable in-order memory model
// plus one task per scenario with hand-computed expected PCs and states.
module tb_fetch_queue;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    int errors = 0;
    int checks = 0;

    int          lat = 1;
    bit          spur = 1'b0;
    int          neg_idx = 0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    fetch_queue #(.DEPTH(4), .MAX_OUT(2), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .pc(pc), .pc_plus4(pc_plus4)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // memory model: responses presented just after negedge, accepts sampled just before posedge
    always @(negedge clk) begin
        #1;
        neg_idx++;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (!rst) begin
            pend_addr.delete();
            pend_due.delete();
        end else if (pend_due.size() > 0 && pend_due[0] <= neg_idx) begin
            imem_rvalid = 1'b1;
            imem_rdata  = data_of(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else if (spur) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        #3;
        if (rst && imem_req && imem_ready) begin
            pend_addr.push_back(imem_addr);
            pend_due.push_back(neg_idx + lat);
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        redirect = 1'b0;
        instr_ready = 1'b0;
        imem_ready = 1'b1;
        spur = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        step();
        step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        checks++; if (instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h expected %h", instr, NOP); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", pc); end
        checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4: got %h expected 4", pc_plus4); end
    endtask

    task automatic test_free_run();
        logic [31:0] exp_pc = 32'h0;
        int first_valid = 0;
        int n = 0;
        lat = 1;
        do_reset();
        instr_ready = 1'b1;
        rst = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL free_first_req: got %b expected 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL free_first_addr: got %h expected 0", imem_addr); end
        for (int c = 1; c <= 14; c++) begin
            if (instr_valid && first_valid == 0) first_valid = c;
            if (instr_valid && instr_ready) begin
                checks++; if (pc !== exp_pc) begin errors++; $display("FAIL free_pc: got %h expected %h", pc, exp_pc); end
                checks++; if (instr !== data_of(exp_pc)) begin errors++; $display("FAIL free_instr: got %h expected %h", instr, data_of(exp_pc)); end
                checks++; if (pc_plus4 !== exp_pc + 32'd4) begin errors++; $display("FAIL free_pc_plus4: got %h expected %h", pc_plus4, exp_pc + 32'd4); end
                exp_pc += 32'd4;
                n++;
            end
            step();
        end
        checks++; if (first_valid != 3) begin errors++; $display("FAIL free_latency: got cycle %0d expected 3", first_valid); end
        checks++; if (n != 12) begin errors++; $display("FAIL free_throughput: got %0d pops expected 12", n); end
    endtask

    task automatic test_fill_stall();
        logic [31:0] exp_pc = 32'h0;
        logic [31:0] first_acc = 32'hFFFF_FFFF;
        bit got_acc = 1'b0;
        int n_acc = 0;
        int n = 0;
        lat = 1;
        do_reset();
        rst = 1'b1;
        #1;
        for (int c = 1; c <= 10; c++) begin
            if (imem_req && imem_ready) n_acc++;
            step();
        end
        checks++; if (n_acc != 4) begin errors++; $display("FAIL fill_accepts: got %0d expected 4", n_acc); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL fill_req_low: got %b expected 0", imem_req); end
        checks++; if (dut.count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d expected 4", dut.count); end
        spur = 1'b1;
        step();
        spur = 1'b0;
        step();
        checks++; if (dut.count !== 3'd4) begin errors++; $display("FAIL spurious_count: got %0d expected 4", dut.count); end
        checks++; if (dut.outstanding !== 2'd0) begin errors++; $display("FAIL spurious_out: got %0d expected 0", dut.outstanding); end
        checks++; if (instr_valid !== 1'b1 || pc !== 32'h0) begin errors++; $display("FAIL spurious_head: got valid %b pc %h expected 1 / 0", instr_valid, pc); end
        instr_ready = 1'b1;
        for (int c = 0; c < 40 && n < 8; c++) begin
            if (imem_req && imem_ready && !got_acc) begin first_acc = imem_addr; got_acc = 1'b1; end
            if (instr_valid && instr_ready) begin
                checks++; if (pc !== exp_pc) begin errors++; $display("FAIL drain_pc: got %h expected %h", pc, exp_pc); end
                checks++; if (instr !== data_of(exp_pc)) begin errors++; $display("FAIL drain_instr: got %h expected %h", instr, data_of(exp_pc)); end
                exp_pc += 32'd4;
                n++;
            end
            step();
        end
        checks++; if (first_acc !== 32'h10) begin errors++; $display("FAIL resume_addr: got %h expected 10", first_acc); end
        checks++; if (n != 8) begin errors++; $display("FAIL drain_pops: got %0d expected 8", n); end
    endtask

    task automatic test_imem_stall();
        logic [31:0] exp_pc = 32'h0;
        int n = 0;
        lat = 1;
        do_reset();
        instr_ready = 1'b1;
        rst = 1'b1;
        #1;
        for (int c = 1; c <= 40 && n < 10; c++) begin
            imem_ready = !(c >= 4 && c <= 6);
            if (c >= 4 && c <= 6) begin
                checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL stall_addr: got %h expected c", imem_addr); end
            end
            if (instr_valid && instr_ready) begin
                checks++; if (pc !== exp_pc) begin errors++; $display("FAIL stall_pc: got %h expected %h", pc, exp_pc); end
                exp_pc += 32'd4;
                n++;
            end
            step();
        end
        imem_ready = 1'b1;
        checks++; if (n != 10) begin errors++; $display("FAIL stall_pops: got %0d expected 10", n); end
    endtask

    task automatic test_redirect();
        logic [31:0] exp_pc = 32'h100;
        bit found = 1'b0;
        int n = 0;
        lat = 3;
        do_reset();
        rst = 1'b1;
        #1;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            found = instr_valid && !imem_req && !imem_rvalid && (dut.outstanding == 2'd2);
        end
        checks++; if (!found) begin errors++; $display("FAIL redir_setup: got no cycle with two outstanding expected one"); end
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b expected 0", instr_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_req: got %b expected 0", imem_req); end
        step();
        redirect = 1'b0;
        instr_ready = 1'b1;
        checks++; if (dut.discard !== 2'd2) begin errors++; $display("FAIL redir_discard: got %0d expected 2", dut.discard); end
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL redir_addr: got %h expected 100", imem_addr); end
        for (int c = 0; c < 40 && n < 3; c++) begin
            if (instr_valid && instr_ready) begin
                checks++; if (pc !== exp_pc) begin errors++; $display("FAIL redir_pc: got %h expected %h", pc, exp_pc); end
                checks++; if (instr !== data_of(exp_pc)) begin errors++; $display("FAIL redir_instr: got %h expected %h", instr, data_of(exp_pc)); end
                exp_pc += 32'd4;
                n++;
            end
            step();
        end
        checks++; if (n != 3) begin errors++; $display("FAIL redir_pops: got %0d expected 3", n); end
    endtask

    task automatic test_redirect_resp();
        logic [31:0] exp_pc = 32'h200;
        bit found = 1'b0;
        int n = 0;
        lat = 3;
        do_reset();
        instr_ready = 1'b1;
        rst = 1'b1;
        #1;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            found = imem_rvalid && !imem_req && (dut.outstanding == 2'd2);
        end
        checks++; if (!found) begin errors++; $display("FAIL rresp_setup: got no response cycle expected one"); end
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();
        redirect = 1'b0;
        checks++; if (dut.discard !== 2'd1) begin errors++; $display("FAIL rresp_discard: got %0d expected 1", dut.discard); end
        checks++; if (dut.outstanding !== 2'd1) begin errors++; $display("FAIL rresp_out: got %0d expected 1", dut.outstanding); end
        for (int c = 0; c < 40 && n < 2; c++) begin
            if (instr_valid && instr_ready) begin
                checks++; if (pc !== exp_pc) begin errors++; $display("FAIL rresp_pc: got %h expected %h", pc, exp_pc); end
                checks++; if (instr !== data_of(exp_pc)) begin errors++; $display("FAIL rresp_instr: got %h expected %h", instr, data_of(exp_pc)); end
                exp_pc += 32'd4;
                n++;
            end
            step();
        end
        checks++; if (n != 2) begin errors++; $display("FAIL rresp_pops: got %0d expected 2", n); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc = 32'h200;
        bit found = 1'b0;
        int n = 0;
        lat = 3;
        do_reset();
        instr_ready = 1'b1;
        rst = 1'b1;
        #1;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            found = imem_rvalid && !imem_req && (dut.outstanding == 2'd2);
        end
        checks++; if (!found) begin errors++; $display("FAIL b2b_setup: got no response cycle expected one"); end
        redirect = 1'b1;
        redirect_pc = 32'h0000_0300;
        step();
        redirect_pc = 32'h0000_0200;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL b2b_req: got %b expected 0", imem_req); end
        step();
        redirect = 1'b0;
        checks++; if (dut.discard !== 2'd0) begin errors++; $display("FAIL b2b_discard: got %0d expected 0", dut.discard); end
        checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL b2b_addr: got %h expected 200", imem_addr); end
        for (int c = 0; c < 40 && n < 2; c++) begin
            if (instr_valid && instr_ready) begin
                checks++; if (pc !== exp_pc) begin errors++; $display("FAIL b2b_pc: got %h expected %h", pc, exp_pc); end
                exp_pc += 32'd4;
                n++;
            end
            step();
        end
        checks++; if (n != 2) begin errors++; $display("FAIL b2b_pops: got %0d expected 2", n); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc = 32'hFFFF_FFF8;
        int n = 0;
        lat = 1;
        do_reset();
        instr_ready = 1'b1;
        rst = 1'b1;
        #1;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFA;
        step();
        redirect = 1'b0;
        for (int c = 0; c < 30 && n < 4; c++) begin
            if (instr_valid && instr_ready) begin
                checks++; if (pc !== exp_pc) begin errors++; $display("FAIL wrap_pc: got %h expected %h", pc, exp_pc); end
                checks++; if (pc_plus4 !== exp_pc + 32'd4) begin errors++; $display("FAIL wrap_pc_plus4: got %h expected %h", pc_plus4, exp_pc + 32'd4); end
                exp_pc += 32'd4;
                n++;
            end
            step();
        end
        checks++; if (n != 4) begin errors++; $display("FAIL wrap_pops: got %0d expected 4", n); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_pc = 32'h0;
        bit found = 1'b0;
        int n = 0;
        lat = 3;
        do_reset();
        rst = 1'b1;
        #1;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            found = instr_valid && (dut.outstanding == 2'd2);
        end
        checks++; if (!found) begin errors++; $display("FAIL rmid_setup: got no busy cycle expected one"); end
        rst = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", instr_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rmid_req: got %b expected 0", imem_req); end
        checks++; if (pc !== 32'h0 || instr !== NOP) begin errors++; $display("FAIL rmid_head: got pc %h instr %h expected 0 / %h", pc, instr, NOP); end
        checks++; if (dut.count !== 3'd0) begin errors++; $display("FAIL rmid_count: got %0d expected 0", dut.count); end
        step();
        step();
        lat = 1;
        instr_ready = 1'b1;
        rst = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rmid_restart: got req %b addr %h expected 1 / 0", imem_req, imem_addr); end
        for (int c = 0; c < 30 && n < 3; c++) begin
            if (instr_valid && instr_ready) begin
                checks++; if (pc !== exp_pc) begin errors++; $display("FAIL rmid_pc: got %h expected %h", pc, exp_pc); end
                checks++; if (instr !== data_of(exp_pc)) begin errors++; $display("FAIL rmid_instr: got %h expected %h", instr, data_of(exp_pc)); end
                exp_pc += 32'd4;
                n++;
            end
            step();
        end
        checks++; if (n != 3) begin errors++; $display("FAIL rmid_pops: got %0d expected 3", n); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_fill_stall();
        test_imem_stall();
        test_redirect();
        test_redirect_resp();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
